// File: rtl/dispatch_stage_if.sv
// Rename-to-dispatch handshake bundle: one renamed instruction offered per cycle.
// Valid/ready: the instruction transfers on a rising edge where rename_valid and
// i_ready are both 1; rename_valid must not depend on i_ready.
interface dispatch_stage_if #(
  parameter int PREG_WIDTH    = 7,
  parameter int ROB_WIDTH     = 4,
  parameter int PAYLOAD_WIDTH = 64
);
  logic                     rename_valid;
  logic [PREG_WIDTH-1:0]    rename_prs1;
  logic [PREG_WIDTH-1:0]    rename_prs2;
  logic                     rename_rs1_used;
  logic                     rename_rs2_used;
  logic [PREG_WIDTH-1:0]    rename_prd;
  logic [PREG_WIDTH-1:0]    rename_old_prd;
  logic                     rename_reg_write;
  logic [ROB_WIDTH-1:0]     rename_rob_tag;
  logic [1:0]               rename_fu_type;
  logic [PAYLOAD_WIDTH-1:0] rename_payload;
  logic                     i_ready;

  modport master (
    output rename_valid, rename_prs1, rename_prs2, rename_rs1_used, rename_rs2_used,
           rename_prd, rename_old_prd, rename_reg_write, rename_rob_tag,
           rename_fu_type, rename_payload,
    input  i_ready
  );

  modport slave (
    input  rename_valid, rename_prs1, rename_prs2, rename_rs1_used, rename_rs2_used,
           rename_prd, rename_old_prd, rename_reg_write, rename_rob_tag,
           rename_fu_type, rename_payload,
    output i_ready
  );
endinterface

// File: rtl/dispatch_stage.sv
// Single-entry dispatch slot: tracks operand readiness against a physical-register
// busy table and hands the instruction to one reservation station plus the ROB.
module dispatch_stage #(
  parameter int PREG_WIDTH    = 7,
  parameter int ROB_WIDTH     = 4,
  parameter int PAYLOAD_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  dispatch_stage_if.slave          rn,
  input  logic                     wb_en,
  input  logic [PREG_WIDTH-1:0]    wb_preg,
  input  logic                     rob_ready,
  input  logic                     rs_alu_ready,
  input  logic                     rs_lsu_ready,
  input  logic                     rs_br_ready,
  input  logic                     branch_mispredict,
  output logic                     rob_alloc_valid,
  output logic                     rs_alu_valid,
  output logic                     rs_lsu_valid,
  output logic                     rs_br_valid,
  output logic [PREG_WIDTH-1:0]    out_prs1,
  output logic [PREG_WIDTH-1:0]    out_prs2,
  output logic                     out_prs1_rdy,
  output logic                     out_prs2_rdy,
  output logic [PREG_WIDTH-1:0]    out_prd,
  output logic [PREG_WIDTH-1:0]    out_old_prd,
  output logic                     out_reg_write,
  output logic [ROB_WIDTH-1:0]     out_rob_tag,
  output logic [PAYLOAD_WIDTH-1:0] out_payload
);
  localparam int NUM_PREGS = 1 << PREG_WIDTH;

  localparam logic [1:0] FU_ALU = 2'd0;
  localparam logic [1:0] FU_LSU = 2'd1;
  localparam logic [1:0] FU_BR  = 2'd2;

  logic                     slot_valid;
  logic [PREG_WIDTH-1:0]    s_prs1, s_prs2, s_prd, s_old_prd;
  logic                     s_rdy1, s_rdy2, s_reg_write;
  logic [ROB_WIDTH-1:0]     s_rob_tag;
  logic [1:0]               s_fu_type;
  logic [PAYLOAD_WIDTH-1:0] s_payload;
  logic [NUM_PREGS-1:0]     busy;

  logic is_alu, is_lsu, is_br, tgt_ready, fire, accept;
  logic wb_hit1, wb_hit2, cap_rdy1, cap_rdy2;

  // fu_type 3 (illegal) goes to the ALU station, which raises the exception.
  assign is_lsu    = (s_fu_type == FU_LSU);
  assign is_br     = (s_fu_type == FU_BR);
  assign is_alu    = !is_lsu && !is_br;
  assign tgt_ready = (is_alu && rs_alu_ready) || (is_lsu && rs_lsu_ready) ||
                     (is_br && rs_br_ready);
  assign fire      = slot_valid && rob_ready && tgt_ready && !branch_mispredict;

  assign rn.i_ready = (!slot_valid || fire) && !branch_mispredict;
  assign accept     = rn.rename_valid && rn.i_ready;

  assign rob_alloc_valid = fire;
  assign rs_alu_valid    = fire && is_alu;
  assign rs_lsu_valid    = fire && is_lsu;
  assign rs_br_valid     = fire && is_br;

  // Same-cycle wakeup is bypassed both into the capture and onto the held slot.
  assign cap_rdy1 = !rn.rename_rs1_used || (rn.rename_prs1 == '0) || !busy[rn.rename_prs1] ||
                    (wb_en && (wb_preg == rn.rename_prs1));
  assign cap_rdy2 = !rn.rename_rs2_used || (rn.rename_prs2 == '0) || !busy[rn.rename_prs2] ||
                    (wb_en && (wb_preg == rn.rename_prs2));
  assign wb_hit1  = wb_en && (wb_preg == s_prs1);
  assign wb_hit2  = wb_en && (wb_preg == s_prs2);

  assign out_prs1      = s_prs1;
  assign out_prs2      = s_prs2;
  assign out_prs1_rdy  = s_rdy1 || wb_hit1;
  assign out_prs2_rdy  = s_rdy2 || wb_hit2;
  assign out_prd       = s_prd;
  assign out_old_prd   = s_old_prd;
  assign out_reg_write = s_reg_write;
  assign out_rob_tag   = s_rob_tag;
  assign out_payload   = s_payload;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_valid  <= 1'b0;
      s_prs1      <= '0;
      s_prs2      <= '0;
      s_rdy1      <= 1'b0;
      s_rdy2      <= 1'b0;
      s_prd       <= '0;
      s_old_prd   <= '0;
      s_reg_write <= 1'b0;
      s_rob_tag   <= '0;
      s_fu_type   <= '0;
      s_payload   <= '0;
    end else if (accept) begin
      slot_valid  <= 1'b1;
      s_prs1      <= rn.rename_prs1;
      s_prs2      <= rn.rename_prs2;
      s_rdy1      <= cap_rdy1;
      s_rdy2      <= cap_rdy2;
      s_prd       <= rn.rename_prd;
      s_old_prd   <= rn.rename_old_prd;
      s_reg_write <= rn.rename_reg_write;
      s_rob_tag   <= rn.rename_rob_tag;
      s_fu_type   <= rn.rename_fu_type;
      s_payload   <= rn.rename_payload;
    end else begin
      if (fire || branch_mispredict) slot_valid <= 1'b0;
      if (wb_hit1) s_rdy1 <= 1'b1;
      if (wb_hit2) s_rdy2 <= 1'b1;
    end
  end

  // Set after clear so a same-cycle allocate of the written-back preg wins.
  // A squash leaves the table alone; stale bits clear on writeback or reallocation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      if (wb_en) busy[wb_preg] <= 1'b0;
      if (accept && rn.rename_reg_write && (rn.rename_prd != '0)) busy[rn.rename_prd] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dispatch_stage.sv
// Directed bench for dispatch_stage: per-cycle vector table plus hand-written
// sequences for reset state, pass-through fields and asynchronous reset mid-flight.
module tb_dispatch_stage;
  localparam int PW  = 7;
  localparam int RW  = 4;
  localparam int PLW = 64;

  logic clk, reset;
  logic wb_en, rob_ready, rs_alu_ready, rs_lsu_ready, rs_br_ready, branch_mispredict;
  logic [PW-1:0] wb_preg;
  logic rob_alloc_valid, rs_alu_valid, rs_lsu_valid, rs_br_valid;
  logic [PW-1:0] out_prs1, out_prs2, out_prd, out_old_prd;
  logic out_prs1_rdy, out_prs2_rdy, out_reg_write;
  logic [RW-1:0] out_rob_tag;
  logic [PLW-1:0] out_payload;

  int checks = 0;
  int errors = 0;

  dispatch_stage_if #(.PREG_WIDTH(PW), .ROB_WIDTH(RW), .PAYLOAD_WIDTH(PLW)) rn ();

  dispatch_stage #(.PREG_WIDTH(PW), .ROB_WIDTH(RW), .PAYLOAD_WIDTH(PLW)) dut (
    .clk(clk), .reset(reset), .rn(rn.slave),
    .wb_en(wb_en), .wb_preg(wb_preg), .rob_ready(rob_ready),
    .rs_alu_ready(rs_alu_ready), .rs_lsu_ready(rs_lsu_ready), .rs_br_ready(rs_br_ready),
    .branch_mispredict(branch_mispredict),
    .rob_alloc_valid(rob_alloc_valid), .rs_alu_valid(rs_alu_valid),
    .rs_lsu_valid(rs_lsu_valid), .rs_br_valid(rs_br_valid),
    .out_prs1(out_prs1), .out_prs2(out_prs2),
    .out_prs1_rdy(out_prs1_rdy), .out_prs2_rdy(out_prs2_rdy),
    .out_prd(out_prd), .out_old_prd(out_old_prd), .out_reg_write(out_reg_write),
    .out_rob_tag(out_rob_tag), .out_payload(out_payload)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rv; logic [1:0] fu; logic [PW-1:0] p1; logic u1; logic [PW-1:0] p2; logic u2;
    logic [PW-1:0] prd; logic rw;
    logic wb; logic [PW-1:0] wbp; logic robr, alur, lsur, brr, mis;
    logic e_irdy, e_rob, e_alu, e_lsu, e_br, chk_fields, e_r1, e_r2; logic [PW-1:0] e_prd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rv, input logic [1:0] fu, input logic [PW-1:0] p1,
                              input logic u1, input logic [PW-1:0] p2, input logic u2,
                              input logic [PW-1:0] prd, input logic rw);
    vec_t v;
    v.rv = rv; v.fu = fu; v.p1 = p1; v.u1 = u1; v.p2 = p2; v.u2 = u2; v.prd = prd; v.rw = rw;
    v.wb = 1'b0; v.wbp = '0; v.robr = 1'b1; v.alur = 1'b1; v.lsur = 1'b1; v.brr = 1'b1;
    v.mis = 1'b0;
    v.e_irdy = 1'b0; v.e_rob = 1'b0; v.e_alu = 1'b0; v.e_lsu = 1'b0; v.e_br = 1'b0;
    v.chk_fields = 1'b0; v.e_r1 = 1'b0; v.e_r2 = 1'b0; v.e_prd = '0;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t vi, input logic irdy, input logic rob, input logic alu,
                              input logic lsu, input logic br, input logic chkf,
                              input logic r1, input logic r2, input logic [PW-1:0] prd);
    vec_t v = vi;
    v.e_irdy = irdy; v.e_rob = rob; v.e_alu = alu; v.e_lsu = lsu; v.e_br = br;
    v.chk_fields = chkf; v.e_r1 = r1; v.e_r2 = r2; v.e_prd = prd;
    return v;
  endfunction

  // Driver tasks
  task automatic drive_idle();
    rn.rename_valid = 1'b0; rn.rename_prs1 = '0; rn.rename_prs2 = '0;
    rn.rename_rs1_used = 1'b0; rn.rename_rs2_used = 1'b0; rn.rename_prd = '0;
    rn.rename_old_prd = '0; rn.rename_reg_write = 1'b0; rn.rename_rob_tag = '0;
    rn.rename_fu_type = '0; rn.rename_payload = '0;
    wb_en = 1'b0; wb_preg = '0; rob_ready = 1'b1; rs_alu_ready = 1'b1;
    rs_lsu_ready = 1'b1; rs_br_ready = 1'b1; branch_mispredict = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    rn.rename_valid = v.rv; rn.rename_fu_type = v.fu;
    rn.rename_prs1 = v.p1; rn.rename_rs1_used = v.u1;
    rn.rename_prs2 = v.p2; rn.rename_rs2_used = v.u2;
    rn.rename_prd = v.prd; rn.rename_reg_write = v.rw;
    rn.rename_old_prd = v.prd + 7'd1; rn.rename_rob_tag = v.prd[RW-1:0];
    rn.rename_payload = {57'h0, v.prd};
    wb_en = v.wb; wb_preg = v.wbp; rob_ready = v.robr; rs_alu_ready = v.alur;
    rs_lsu_ready = v.lsur; rs_br_ready = v.brr; branch_mispredict = v.mis;
  endtask

  // Scoreboard compare
  task automatic chk(input string name, input int idx, input logic [PLW-1:0] act,
                     input logic [PLW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic build_table();
    vec_t v;
    // 0: empty slot, offer producer of preg 40
    v = mk(1, 0, 5, 1, 6, 1, 40, 1);   vecs.push_back(ex(v, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    // 1: producer fires; consumer of 40 accepted back-to-back
    v = mk(1, 0, 40, 1, 6, 1, 41, 1);  vecs.push_back(ex(v, 1, 1, 1, 0, 0, 1, 1, 1, 40));
    // 2: consumer held by full ALU RS, prs1 not ready
    v = mk(0, 0, 0, 0, 0, 0, 0, 0); v.alur = 0; vecs.push_back(ex(v, 0, 0, 0, 0, 0, 1, 0, 1, 41));
    // 3: wakeup of 40 while held -> bypass
    v = mk(0, 0, 0, 0, 0, 0, 0, 0); v.alur = 0; v.wb = 1; v.wbp = 40;
    vecs.push_back(ex(v, 0, 0, 0, 0, 0, 1, 1, 1, 41));
    // 4: stored readiness after wakeup
    v = mk(0, 0, 0, 0, 0, 0, 0, 0); v.alur = 0; vecs.push_back(ex(v, 0, 0, 0, 0, 0, 1, 1, 1, 41));
    // 5: consumer fires, LSU op (reads busy 41) accepted
    v = mk(1, 1, 41, 1, 0, 1, 42, 1);  vecs.push_back(ex(v, 1, 1, 1, 0, 0, 1, 1, 1, 41));
    // 6-8: LSU RS full for 3 cycles while rename offers an op with unused sources
    for (int i = 0; i < 3; i++) begin
      v = mk(1, 0, 1, 0, 41, 0, 43, 1); v.lsur = 0;
      vecs.push_back(ex(v, 0, 0, 0, 0, 0, 1, 0, 1, 42));
    end
    // 9: LSU RS frees: fire and accept in the same cycle
    v = mk(1, 0, 1, 0, 41, 0, 43, 1);  vecs.push_back(ex(v, 1, 1, 0, 1, 0, 1, 0, 1, 42));
    // 10: unused sources captured ready despite busy[41]; offer branch
    v = mk(1, 2, 0, 1, 0, 1, 0, 0);    vecs.push_back(ex(v, 1, 1, 1, 0, 0, 1, 1, 1, 43));
    // 11: ROB full, BR RS free -> no strobes
    v = mk(0, 0, 0, 0, 0, 0, 0, 0); v.robr = 0; vecs.push_back(ex(v, 0, 0, 0, 0, 0, 1, 1, 1, 0));
    // 12: BR RS full
    v = mk(0, 0, 0, 0, 0, 0, 0, 0); v.brr = 0; vecs.push_back(ex(v, 0, 0, 0, 0, 0, 1, 1, 1, 0));
    // 13: mispredict squashes the slot and blocks the offered producer of 44
    v = mk(1, 0, 0, 0, 0, 0, 44, 1); v.mis = 1; vecs.push_back(ex(v, 0, 0, 0, 0, 0, 1, 1, 1, 0));
    // 14: slot empty; consumer of 44 (never allocated) and 42 (still busy)
    v = mk(1, 0, 44, 1, 42, 1, 45, 1); vecs.push_back(ex(v, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    // 15: fires with rdy1=1, rdy2=0
    v = mk(0, 0, 0, 0, 0, 0, 0, 0);    vecs.push_back(ex(v, 1, 1, 1, 0, 0, 1, 1, 0, 45));
    // 16: allocate 50 with same-cycle writeback of 50 -> stays busy
    v = mk(1, 0, 0, 1, 0, 1, 50, 1); v.wb = 1; v.wbp = 50;
    vecs.push_back(ex(v, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    // 17: producer fires; branch consumer of 50 accepted
    v = mk(1, 2, 50, 1, 0, 1, 51, 0);  vecs.push_back(ex(v, 1, 1, 1, 0, 0, 1, 1, 1, 50));
    // 18: branch fires with prs1 not ready
    v = mk(0, 0, 0, 0, 0, 0, 0, 0);    vecs.push_back(ex(v, 1, 1, 0, 0, 1, 1, 0, 1, 51));
    // 19: empty; offer illegal fu_type 3
    v = mk(1, 3, 0, 0, 0, 0, 0, 0);    vecs.push_back(ex(v, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    // 20: illegal op goes to ALU; capture of busy 42 with same-cycle wakeup
    v = mk(1, 0, 42, 1, 0, 0, 52, 1); v.wb = 1; v.wbp = 42;
    vecs.push_back(ex(v, 1, 1, 1, 0, 0, 1, 1, 1, 0));
    // 21: stored bypassed readiness
    v = mk(0, 0, 0, 0, 0, 0, 0, 0);    vecs.push_back(ex(v, 1, 1, 1, 0, 0, 1, 1, 1, 52));
    // 22: drained
    v = mk(0, 0, 0, 0, 0, 0, 0, 0);    vecs.push_back(ex(v, 1, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    reset = 1'b0;
    drive_idle();
    build_table();

    // Reset state
    @(negedge clk);
    chk("rst_i_ready", 0, rn.i_ready, 1'b1);
    chk("rst_rob", 0, rob_alloc_valid, 1'b0);
    chk("rst_rs", 0, {rs_alu_valid, rs_lsu_valid, rs_br_valid}, 3'b000);
    chk("rst_prd", 0, out_prd, '0);
    chk("rst_srcs", 0, {out_prs1, out_prs2, out_prs1_rdy, out_prs2_rdy}, '0);
    chk("rst_payload", 0, out_payload, '0);
    chk("rst_misc", 0, {out_old_prd, out_reg_write, out_rob_tag}, '0);
    @(posedge clk); #1 reset = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1 drive_vec(vecs[i]);
      @(negedge clk);
      chk("i_ready", i, rn.i_ready, vecs[i].e_irdy);
      chk("rob_alloc", i, rob_alloc_valid, vecs[i].e_rob);
      chk("rs_alu", i, rs_alu_valid, vecs[i].e_alu);
      chk("rs_lsu", i, rs_lsu_valid, vecs[i].e_lsu);
      chk("rs_br", i, rs_br_valid, vecs[i].e_br);
      if (vecs[i].chk_fields) begin
        chk("prs1_rdy", i, out_prs1_rdy, vecs[i].e_r1);
        chk("prs2_rdy", i, out_prs2_rdy, vecs[i].e_r2);
        chk("out_prd", i, out_prd, vecs[i].e_prd);
      end
    end

    // Pass-through fields, then async reset while the slot is firing
    @(posedge clk); #1 drive_idle();
    rn.rename_valid = 1'b1; rn.rename_fu_type = 2'd1; rn.rename_prd = 7'd60;
    rn.rename_reg_write = 1'b1; rn.rename_old_prd = 7'd61; rn.rename_rob_tag = 4'hb;
    rn.rename_payload = 64'hdead_beef_0123_4567;
    @(posedge clk); #1 rn.rename_valid = 1'b0;
    @(negedge clk);
    chk("pt_rob", 0, rob_alloc_valid, 1'b1);
    chk("pt_lsu", 0, rs_lsu_valid, 1'b1);
    chk("pt_payload", 0, out_payload, 64'hdead_beef_0123_4567);
    chk("pt_tag", 0, {out_rob_tag, out_old_prd, out_reg_write}, {4'hb, 7'd61, 1'b1});
    #2 reset = 1'b0;
    #1;
    chk("ares_rob", 0, rob_alloc_valid, 1'b0);
    chk("ares_lsu", 0, rs_lsu_valid, 1'b0);
    chk("ares_fields", 0, {out_prd, out_payload}, '0);
    @(posedge clk); #1 reset = 1'b1;
    // Busy bits for 50 and 60 must be gone after reset
    rn.rename_valid = 1'b1; rn.rename_fu_type = 2'd0; rn.rename_prs1 = 7'd50;
    rn.rename_rs1_used = 1'b1; rn.rename_prs2 = 7'd60; rn.rename_rs2_used = 1'b1;
    rn.rename_prd = 7'd0; rn.rename_reg_write = 1'b0;
    @(posedge clk); #1 rn.rename_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", 0, {out_prs1_rdy, out_prs2_rdy}, 2'b11);
    chk("post_rst_alu", 0, {rob_alloc_valid, rs_alu_valid}, 2'b11);
    @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
